// File: rtl/pkt_det_pkg.sv
// +------------------------------------------------------------------+
// | pkt_det_pkg: shared constants and sample type for packet detect  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package pkt_det_pkg;
  localparam int STF_LEN = 16;
  localparam int CORR_W  = 29;
  localparam int PWR_W   = 28;

  typedef struct packed {
    logic signed [CORR_W-1:0] re;
    logic signed [CORR_W-1:0] im;
    logic        [PWR_W-1:0]  pwr;
  } corr_sample_t;
endpackage

`default_nettype wire

// File: rtl/corr_window_hist.sv
// +------------------------------------------------------------------+
// | corr_window_hist: 1R1W sample history, read-before-write at the  |
// | shared address (combinational read). Rev 1.0                     |
// +------------------------------------------------------------------+
`default_nettype none

module corr_window_hist #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 86,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/module1_packet_detect_corr_window.sv
// +------------------------------------------------------------------+
// | module1_packet_detect_corr_window: WIN-sample running sums of    |
// | delayed-conjugate correlation and power. Rev 1.0                 |
// +------------------------------------------------------------------+
`default_nettype none

module module1_packet_detect_corr_window
  import pkt_det_pkg::*;
#(
  parameter  int WIN   = STF_LEN,
  parameter  int IN_W  = CORR_W,
  parameter  int PWR_W = pkt_det_pkg::PWR_W,
  localparam int ACC_W = IN_W + $clog2(WIN),
  localparam int APW   = PWR_W + $clog2(WIN)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  corr_re,
  input  logic [IN_W-1:0]  corr_im,
  input  logic [PWR_W-1:0] pwr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_re,
  output logic [ACC_W-1:0] sum_im,
  output logic [APW-1:0]   sum_pwr,
  output logic             win_full
);

  localparam int         PW    = $clog2(WIN);
  localparam int         DW    = 2*IN_W + PWR_W;
  localparam logic [PW:0] c_win = (PW+1)'(WIN);

  logic [PW-1:0]    r_wp;
  logic [PW:0]      r_cnt;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_sum_re;
  logic [ACC_W-1:0] r_sum_im;
  logic [APW-1:0]   r_sum_pwr;

  logic             w_full;
  logic             w_accept;
  logic             w_last;
  logic [DW-1:0]    w_rd;
  logic [DW-1:0]    w_old;
  logic [IN_W-1:0]  w_old_re;
  logic [IN_W-1:0]  w_old_im;
  logic [PWR_W-1:0] w_old_pwr;

  assign w_full   = (r_cnt == c_win);
  assign in_ready = ~clr & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  // This accept completes (or keeps) a full window, so the sums become valid.
  assign w_last   = (r_cnt >= c_win - 1'b1);

  corr_window_hist #(
    .DEPTH (WIN),
    .DW    (DW)
  ) u_hist (
    .clk   (ap_clk),
    .we    (w_accept),
    .addr  (r_wp),
    .wdata ({corr_re, corr_im, pwr}),
    .rdata (w_rd)
  );

  // Entries not yet written since reset/clr must contribute nothing.
  assign w_old     = w_full ? w_rd : '0;
  assign w_old_re  = w_old[DW-1 -: IN_W];
  assign w_old_im  = w_old[PWR_W +: IN_W];
  assign w_old_pwr = w_old[PWR_W-1:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wp        <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_sum_re    <= '0;
      r_sum_im    <= '0;
      r_sum_pwr   <= '0;
    end else if (clr) begin
      r_wp        <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_sum_re    <= '0;
      r_sum_im    <= '0;
      r_sum_pwr   <= '0;
    end else if (w_accept) begin
      r_wp        <= r_wp + 1'b1;
      if (!w_full) r_cnt <= r_cnt + 1'b1;
      r_out_valid <= w_last;
      r_sum_re    <= r_sum_re + {{PW{corr_re[IN_W-1]}}, corr_re}
                              - {{PW{w_old_re[IN_W-1]}}, w_old_re};
      r_sum_im    <= r_sum_im + {{PW{corr_im[IN_W-1]}}, corr_im}
                              - {{PW{w_old_im[IN_W-1]}}, w_old_im};
      r_sum_pwr   <= r_sum_pwr + {{PW{1'b0}}, pwr} - {{PW{1'b0}}, w_old_pwr};
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign sum_re    = r_sum_re;
  assign sum_im    = r_sum_im;
  assign sum_pwr   = r_sum_pwr;
  assign win_full  = w_full;

endmodule

`default_nettype wire

// File: tb/tb_module1_packet_detect_corr_window.sv
// +------------------------------------------------------------------+
// | tb_module1_packet_detect_corr_window: directed + random bench    |
// | with a queue-based window model. Rev 1.0                         |
// +------------------------------------------------------------------+
`default_nettype none

module tb_module1_packet_detect_corr_window;
  import pkt_det_pkg::*;

  localparam int WIN   = 16;
  localparam int IN_W  = 29;
  localparam int PW_W  = 28;
  localparam int ACC_W = IN_W + $clog2(WIN);
  localparam int APW   = PW_W + $clog2(WIN);

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  corr_re;
  logic [IN_W-1:0]  corr_im;
  logic [PW_W-1:0]  pwr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum_re;
  logic [ACC_W-1:0] sum_im;
  logic [APW-1:0]   sum_pwr;
  logic             win_full;

  module1_packet_detect_corr_window #(
    .WIN   (WIN),
    .IN_W  (IN_W),
    .PWR_W (PW_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .corr_re   (corr_re),
    .corr_im   (corr_im),
    .pwr       (pwr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_re    (sum_re),
    .sum_im    (sum_im),
    .sum_pwr   (sum_pwr),
    .win_full  (win_full)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  // Model: the last (up to WIN) accepted samples since reset/clr.
  corr_sample_t q[$];
  logic         m_ov;

  function automatic logic [63:0] acc_bits(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return 64'(t);
  endfunction

  function automatic logic [63:0] pwr_bits(input longint v);
    logic [APW-1:0] t;
    t = v[APW-1:0];
    return 64'(t);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
  endtask

  task automatic check_outputs();
    longint sr, si, sp;
    sr = 0; si = 0; sp = 0;
    foreach (q[i]) begin
      sr += longint'(q[i].re);
      si += longint'(q[i].im);
      sp += longint'(q[i].pwr);
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("win_full",  64'(win_full),  64'(q.size() == WIN));
    chk("sum_re",    64'(sum_re),    acc_bits(sr));
    chk("sum_im",    64'(sum_im),    acc_bits(si));
    chk("sum_pwr",   64'(sum_pwr),   pwr_bits(sp));
  endtask

  // One clock: drive at negedge, check ready before the edge, outputs after it.
  task automatic step(input logic v, input logic [IN_W-1:0] re, input logic [IN_W-1:0] im,
                      input logic [PW_W-1:0] p, input logic ordy, input logic c);
    logic exp_rdy, acc;
    corr_sample_t s;
    in_valid = v; corr_re = re; corr_im = im; pwr = p; out_ready = ordy; clr = c;
    #1;
    exp_rdy = !c && (!m_ov || ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge ap_clk);
    #1;
    if (c) begin
      model_reset();
    end else if (acc) begin
      s.re = re; s.im = im; s.pwr = p;
      q.push_back(s);
      if (q.size() > WIN) void'(q.pop_front());
      m_ov = (q.size() == WIN);
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    check_outputs();
    @(negedge ap_clk);
  endtask

  task automatic rnd_step(input int pv, input int pr, input int pc);
    logic [IN_W-1:0] re, im;
    logic [PW_W-1:0] p;
    re = IN_W'($urandom);
    im = IN_W'($urandom);
    p  = PW_W'($urandom);
    step($urandom_range(0, 99) < pv, re, im, p, $urandom_range(0, 99) < pr,
         $urandom_range(0, 99) < pc);
  endtask

  initial begin
    logic [IN_W-1:0] neg_max;
    logic [PW_W-1:0] pwr_max;
    ap_rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    corr_re = '0; corr_im = '0; pwr = '0;
    model_reset();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_outputs();
    ap_rst_n = 1'b1;

    // Fill with re=1, im=-1, pwr=2.
    for (int k = 0; k < WIN; k++) step(1'b1, 29'd1, -29'sd1, 28'd2, 1'b1, 1'b0);
    chk("s1_sum_re",  64'(sum_re),  acc_bits(16));
    chk("s1_sum_im",  64'(sum_im),  acc_bits(-16));
    chk("s1_sum_pwr", 64'(sum_pwr), pwr_bits(32));
    chk("s1_full",    64'(win_full), 64'(1));

    // Eviction: each re=3 replaces a 1.
    for (int k = 0; k < WIN; k++) begin
      step(1'b1, 29'd3, -29'sd1, 28'd2, 1'b1, 1'b0);
      chk("s2_ramp", 64'(sum_re), acc_bits(18 + 2*k));
    end
    step(1'b1, 29'd3, -29'sd1, 28'd2, 1'b1, 1'b0);
    chk("s2_hold", 64'(sum_re), acc_bits(48));

    // Backpressure with input pending.
    for (int k = 0; k < 5; k++) step(1'b1, 29'd7, 29'd5, 28'd9, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 29'd7, 29'd5, 28'd9, 1'b1, 1'b0);

    // Extremes.
    neg_max = 29'h1000_0000;
    pwr_max = 28'hFFF_FFFF;
    for (int k = 0; k < 2*WIN; k++)
      step(1'b1, neg_max, IN_W'($urandom), pwr_max, 1'b1, 1'b0);
    chk("s4_sum_re",  64'(sum_re),  acc_bits(-(longint'(1) << 32)));
    chk("s4_sum_pwr", 64'(sum_pwr), pwr_bits(longint'(16) * 268435455));

    // Flush mid-fill, then refill.
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) rnd_step(100, 100, 0);
    step(1'b1, 29'd11, 29'd11, 28'd11, 1'b1, 1'b1);
    for (int k = 0; k < WIN; k++) begin
      chk("s5_ov_low", 64'(out_valid), 64'(0));
      rnd_step(100, 100, 0);
    end
    chk("s5_ov_high", 64'(out_valid), 64'(1));

    // Asynchronous reset mid-window.
    for (int k = 0; k < 7; k++) rnd_step(100, 100, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int k = 0; k < 400; k++) rnd_step(70, 65, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
